// File: rtl/block_ram_sdp.sv
// block_ram_sdp
// Simple-dual-port block RAM: one write port and one read port on a single
// clock. It provides read-valid signalling, selectable read-during-write
// behaviour and an optional post-reset clear sequencer.
//
// Ports:
//   clk     in  1       single clock, rising edge
//   rst     in  1       synchronous, active-high reset
//   w_en    in  1       write strobe
//   w_addr  in  ADDR_W  write address
//   w_data  in  DATA_W  write data
//   r_en    in  1       read strobe
//   r_addr  in  ADDR_W  read address
//   r_data  out DATA_W  read data; holds its value between reads
//   r_valid out 1       one-cycle pulse marking new r_data
//   busy    out 1       high while the clear sequencer owns the RAM
//
// Handshake: there is no back-pressure. A write or read strobe is taken on any
// rising edge where busy is low and rst is low. Every read that is taken
// produces exactly one r_valid pulse, in issue order, after the read latency.
//
// Optional feature: define BLOCK_RAM_SDP_OUTREG_EN to add an output register
// after the RAM read register. Read latency then becomes 2 cycles instead of 1.
module block_ram_sdp #(
  parameter int                DATA_W       = 2,
  parameter int                ADDR_W       = 4,
  parameter int                DEPTH        = 16,
  parameter string             INIT_FILE    = "",
  parameter int                CLEAR_ON_RST = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL    = '0,
  parameter int                RDW_MODE     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              busy
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam state_e            RST_STATE = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              w_in_range;
  logic              r_in_range;

  // Addresses at or above DEPTH have no backing storage.
  assign w_in_range = ({1'b0, w_addr} < DEPTH_L);
  assign r_in_range = ({1'b0, r_addr} < DEPTH_L);

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = w_addr;
    mem_wdata  = w_data;
    case (state_q)
      ST_CLEAR: begin
        // The sequencer owns the write port. User strobes are ignored here.
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = CLEAR_VAL;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = ST_READY;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        mem_we = w_en && w_in_range;
        if (r_en) begin
          rd_valid_d = 1'b1;
          if (!r_in_range) begin
            rd_data_d = '0;
          end else if ((RDW_MODE != 0) && w_en && (w_addr == r_addr)) begin
            // Write-first: forward the incoming word instead of the stored one.
            rd_data_d = w_data;
          end else begin
            rd_data_d = mem[r_addr];
          end
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RST_STATE;
      clr_cnt_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage has no reset. Contents only change through the write port or the
  // clear sequencer.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign busy = (state_q == ST_CLEAR);

`ifdef BLOCK_RAM_SDP_OUTREG_EN
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  // The second stage loads only when the first stage presents a new word.
  // This way r_data still holds its value between reads.
  always_comb begin
    out_valid_d = rd_valid_q;
    out_data_d  = rd_valid_q ? rd_data_q : out_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign r_data  = out_data_q;
  assign r_valid = out_valid_q;
`else
  assign r_data  = rd_data_q;
  assign r_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_block_ram_sdp.sv
// Testbench for block_ram_sdp. Three instances share one stimulus stream:
//   a: defaults (DEPTH 16, old-data read-during-write, no clear)
//   b: CLEAR_ON_RST=1, CLEAR_VAL=2, write-first read-during-write
//   c: DEPTH=12, so addresses 12..15 are out of range
// Expected read results are pushed per instance when a read is issued. The
// tag is {due_cycle, data}. A negedge monitor pops these entries and compares.
module tb_block_ram_sdp;

`ifdef BLOCK_RAM_SDP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       w_en = 1'b0;
  logic [3:0] w_addr = '0;
  logic [1:0] w_data = '0;
  logic       r_en = 1'b0;
  logic [3:0] r_addr = '0;

  logic [1:0] r_data_a, r_data_b, r_data_c;
  logic       r_valid_a, r_valid_b, r_valid_c;
  logic       busy_a, busy_b, busy_c;

  block_ram_sdp u_a (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .r_en(r_en), .r_addr(r_addr), .r_data(r_data_a), .r_valid(r_valid_a),
    .busy(busy_a)
  );

  block_ram_sdp #(.CLEAR_ON_RST(1), .CLEAR_VAL(2'd2), .RDW_MODE(1)) u_b (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .r_en(r_en), .r_addr(r_addr), .r_data(r_data_b), .r_valid(r_valid_b),
    .busy(busy_b)
  );

  block_ram_sdp #(.DEPTH(12)) u_c (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .r_en(r_en), .r_addr(r_addr), .r_data(r_data_c), .r_valid(r_valid_c),
    .busy(busy_c)
  );

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[3][$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_one(input int k, input logic v, input logic [1:0] d);
    logic [17:0] e;
    if (v) begin
      if (exp_q[k].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid_%0d: got r_valid=1 data=%0d expected no read (cycle %0d)",
                 k, d, cyc);
      end else begin
        e = exp_q[k].pop_front();
        check($sformatf("r_data_%0d", k), int'(d), int'(e[1:0]));
        check($sformatf("latency_%0d", k), cyc, int'(e[17:2]));
      end
    end else if (exp_q[k].size() != 0 && int'(exp_q[k][0][17:2]) < cyc) begin
      e = exp_q[k].pop_front();
      checks++;
      errors++;
      $display("FAIL missing_valid_%0d: got no r_valid by cycle %0d expected at cycle %0d",
               k, cyc, int'(e[17:2]));
    end
  endtask

  always @(negedge clk) begin
    mon_one(0, r_valid_a, r_data_a);
    mon_one(1, r_valid_b, r_data_b);
    mon_one(2, r_valid_c, r_data_c);
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+#1. Applies one cycle of stimulus and pushes the expected
  // read results for the instances selected in pm, then advances one edge.
  task automatic drive(input bit rs, input bit we, input int wa, input int wd,
                       input bit re, input int ra,
                       input int ea, input int eb, input int ec, input bit [2:0] pm);
    rst    = rs;
    w_en   = we;
    w_addr = wa[3:0];
    w_data = wd[1:0];
    r_en   = re;
    r_addr = ra[3:0];
    if (pm[0]) exp_q[0].push_back({16'(cyc + LAT), 2'(ea)});
    if (pm[1]) exp_q[1].push_back({16'(cyc + LAT), 2'(eb)});
    if (pm[2]) exp_q[2].push_back({16'(cyc + LAT), 2'(ec)});
    @(posedge clk);
    #1;
    rst  = 1'b0;
    w_en = 1'b0;
    r_en = 1'b0;
  endtask

  task automatic rd(input int ra, input int ea, input int eb, input int ec);
    drive(0, 0, 0, 0, 1, ra, ea, eb, ec, 3'b111);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_r_data_a", r_data_a, 0);
    check("rst_r_data_b", r_data_b, 0);
    check("rst_r_data_c", r_data_c, 0);
    check("rst_r_valid_a", r_valid_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_busy_b", busy_b, 1);
    check("rst_busy_c", busy_c, 0);
    rst = 1'b0;

    // While b is clearing, load the 0,1,2,3 pattern into a and c. Each cycle
    // also reads back the word written on the previous cycle. b ignores all of
    // this and must not raise r_valid.
    for (int i = 0; i < 16; i++) begin
      check("busy_b_clearing", busy_b, 1);
      check("busy_a_idle", busy_a, 0);
      drive(0, 1, i, i & 3, i > 0, i - 1,
            (i - 1) & 3, 0, (i - 1) < 12 ? (i - 1) & 3 : 0,
            (i > 0) ? 3'b101 : 3'b000);
    end
    check("busy_b_done", busy_b, 0);

    // Back-to-back reads of every address.
    for (int i = 0; i < 16; i++) begin
      rd(i, i & 3, 2, i < 12 ? i & 3 : 0);
    end
    repeat (3) idle();
    check("hold_r_data_a", r_data_a, 3);
    check("hold_r_data_b", r_data_b, 2);
    check("hold_r_data_c", r_data_c, 0);

    // Read-during-write to address 5 (old value 1 in a and c, 2 in b).
    drive(0, 1, 5, 3, 1, 5, 1, 3, 1, 3'b111);
    rd(5, 3, 3, 3);

    // Write, then read on the next cycle. In c, address 12 is out of range.
    drive(0, 1, 12, 3, 0, 0, 0, 0, 0, 3'b000);
    rd(12, 3, 3, 0);
    rd(11, 3, 2, 3);

    // Out-of-range write and read in c, combined with read-during-write.
    drive(0, 1, 13, 2, 1, 13, 1, 2, 0, 3'b111);
    rd(1, 1, 2, 1);
    rd(13, 2, 2, 0);
    repeat (LAT + 1) idle();

    // A reset in the same cycle as a read cancels the read.
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 3'b000);
    check("rst2_r_data_a", r_data_a, 0);
    check("rst2_r_data_b", r_data_b, 0);
    check("rst2_busy_b", busy_b, 1);

    // Reset again after 7 clear writes: clearing restarts at address 0.
    for (int i = 0; i < 7; i++) begin
      check("busy_b_partial", busy_b, 1);
      idle();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    n = 0;
    while (busy_b && n < 40) begin
      n++;
      idle();
    end
    check("busy_len_restart", n, 16);

    // Memory in a and c survives reset. b is fully cleared.
    rd(7, 3, 2, 3);
    rd(13, 2, 2, 0);
    rd(0, 0, 2, 0);
    repeat (LAT + 2) idle();

    check("drain_q_a", exp_q[0].size(), 0);
    check("drain_q_b", exp_q[1].size(), 0);
    check("drain_q_c", exp_q[2].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of sequence by %0t expected earlier", $time);
    $fatal(1);
  end

endmodule
